universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//   Parametrised successor of the single-bit enable/reset flip-flop: a WIDTH-bit
//   register with true hold-on-disable, synchronous clear, parallel load and
//   left/right shift with serial in/out. A saturating shift counter flags when a
//   loaded word has been fully serialised. Used as the general storage/serialiser
//   element in the sequential-circuit library.
// PARAMETERS
//   WIDTH        8      register width in bits, >= 2
//   RESET_VALUE  '0     value of io_q after reset and after io_clear
// PORTS
//   clock        in   1                  single clock, rising edge
//   reset        in   1                  asynchronous, active-low reset
//   io_clear     in   1                  synchronous clear, highest sync priority
//   io_enable    in   1                  1 = act on io_mode, 0 = hold every register
//   io_mode      in   2                  0 HOLD, 1 LOAD, 2 SHL, 3 SHR
//   io_data      in   WIDTH              parallel load data
//   io_serialIn  in   1                  bit shifted in (LSB on SHL, MSB on SHR)
//   io_q         out  WIDTH              register contents
//   io_serialOut out  1                  bit shifted out: io_q[WIDTH-1] on SHL, io_q[0] otherwise
//   io_count     out  $clog2(WIDTH+1)    shifts since last load/clear, saturating at WIDTH
//   io_done      out  1                  io_count == WIDTH
// BEHAVIOUR
//   - reset low (any time, async): io_q = RESET_VALUE, io_count = 0, io_done = 0.
//     Release is synchronous to clock; first update on the first edge after release.
//   - Per rising edge, priority: io_clear > !io_enable > io_mode.
//   - io_clear=1: io_q <= RESET_VALUE, io_count <= 0, regardless of io_enable/io_mode.
//   - io_enable=0: io_q and io_count hold (unlike the single-bit FF, no forced 0).
//   - HOLD: hold all. LOAD: io_q <= io_data, io_count <= 0.
//   - SHL: io_q <= {io_q[WIDTH-2:0], io_serialIn}; SHR: io_q <= {io_serialIn, io_q[WIDTH-1:1]}.
//     Each shift increments io_count; at WIDTH it stays at WIDTH (no wrap); shifting continues.
//   - Latency: one cycle from sampled inputs to io_q/io_count; io_serialOut and io_done
//     are combinational from registered state and io_mode; no input-to-output comb path
//     except io_mode -> io_serialOut select.
//   - Shift when io_count==WIDTH: data shifts, count remains WIDTH, io_done stays 1.
//   - LOAD and clear in same cycle: clear wins.
// CONFIGURATION
//   Macro USR_PARITY_EN:
//   - defined: extra output io_parity (1 bit) = registered even parity (^) of io_q,
//     updated in the same edge as io_q (parity of next value), RESET_VALUE parity on reset.
//   - undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//   - Package usr_pkg: typedef enum logic [1:0] {USR_HOLD, USR_LOAD, USR_SHL, USR_SHR}
//     usr_mode_e; function for count width.
//   - One sub-module natural: usr_sat_counter (count, clear, inc, saturate at MAX).
//   - Data path, next-state mux and optional parity in the top module.
// TESTING
//   1. reset low mid-shift with io_q=8'hA5 -> io_q=8'h00, io_count=0 immediately, no clock.
//   2. LOAD 8'hB4, then 8x SHL with serialIn=0 -> serialOut seq 1,0,1,1,0,1,0,0;
//      io_q=8'h00, io_count=8, io_done=1; 9th SHL keeps io_count=8.
//   3. LOAD 8'h81, SHR with serialIn=1 once -> io_q=8'hC0, io_count=1, serialOut was 1.
//   4. io_enable=0 with io_mode=LOAD, io_data=8'hFF for 3 cycles -> io_q unchanged.
//   5. io_clear=1 with io_enable=0, io_mode=LOAD -> io_q=RESET_VALUE, io_count=0 next edge.
//   6. USR_PARITY_EN defined: LOAD 8'h07 -> io_parity=1; LOAD 8'h03 -> io_parity=0.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
//   Shared types and helpers for the universal shift register.
//   - usr_mode_e : operating mode selected by io_mode when enabled.
//   - usr_cnt_w  : width of the saturating shift counter for a given WIDTH.
//     The counter must be able to hold the value WIDTH itself.
// -----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'd0,
        USR_LOAD = 2'd1,
        USR_SHL  = 2'd2,
        USR_SHR  = 2'd3
    } usr_mode_e;

    function automatic int usr_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_if
//   Bundles the control, data and status signals of universal_shift_reg.
//   Optional macro: USR_PARITY_EN adds the io_parity status output.
//   Modports:
//     master : drives io_clear/io_enable/io_mode/io_data/io_serialIn,
//              observes io_q/io_serialOut/io_count/io_done[/io_parity]
//     slave  : the register itself (opposite directions)
// -----------------------------------------------------------------------------
interface universal_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = usr_cnt_w(WIDTH);

    logic             io_clear;
    logic             io_enable;
    usr_mode_e        io_mode;
    logic [WIDTH-1:0] io_data;
    logic             io_serialIn;
    logic [WIDTH-1:0] io_q;
    logic             io_serialOut;
    logic [CW-1:0]    io_count;
    logic             io_done;
`ifdef USR_PARITY_EN
    logic             io_parity;
`endif

    modport master (
        output io_clear, io_enable, io_mode, io_data, io_serialIn,
        input  io_q, io_serialOut, io_count, io_done
`ifdef USR_PARITY_EN
        , input io_parity
`endif
    );

    modport slave (
        input  io_clear, io_enable, io_mode, io_data, io_serialIn,
        output io_q, io_serialOut, io_count, io_done
`ifdef USR_PARITY_EN
        , output io_parity
`endif
    );

endinterface

// File: rtl/universal_shift_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// usr_sat_counter
//   Up-counter that saturates at MAX (no wrap). clear_i has priority over
//   inc_i. Asynchronous active-low reset to zero.
//   Ports:
//     clock, reset : clock and async active-low reset
//     clear_i      : synchronous clear to zero
//     inc_i        : increment by one unless already at MAX
//     count_o      : current count
// -----------------------------------------------------------------------------
module usr_sat_counter #(
    parameter int MAX = 8,
    parameter int CW  = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit register with hold-on-disable, synchronous clear, parallel load
//   and left/right shift with serial in/out. A saturating counter tracks shifts
//   since the last load/clear; io_done flags that a word was fully serialised.
//   Optional macro: USR_PARITY_EN adds a registered even-parity output.
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous active-low reset
//     bus   : universal_shift_reg_if.slave (io_clear, io_enable, io_mode,
//             io_data, io_serialIn in; io_q, io_serialOut, io_count,
//             io_done[, io_parity] out)
// -----------------------------------------------------------------------------
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                  clock,
    input logic                  reset,
    universal_shift_reg_if.slave bus
);
    localparam int              CW      = usr_cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CW-1:0]    count;

    // Next-state mux: clear beats disable, disable beats mode.
    always_comb begin
        q_d = q_q;
        if (bus.io_clear) begin
            q_d = RESET_VALUE;
        end else if (bus.io_enable) begin
            case (bus.io_mode)
                USR_LOAD: q_d = bus.io_data;
                USR_SHL:  q_d = {q_q[WIDTH-2:0], bus.io_serialIn};
                USR_SHR:  q_d = {bus.io_serialIn, q_q[WIDTH-1:1]};
                default:  q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // A load restarts the shift count just like a clear does.
    assign cnt_clear = bus.io_clear || (bus.io_enable && (bus.io_mode == USR_LOAD));
    assign cnt_inc   = bus.io_enable &&
                       ((bus.io_mode == USR_SHL) || (bus.io_mode == USR_SHR));

    usr_sat_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_sat_counter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .count_o (count)
    );

`ifdef USR_PARITY_EN
    // Parity is computed from the next value so it lines up with io_q.
    logic parity_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_q <= ^RESET_VALUE;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign bus.io_parity = parity_q;
`endif

    assign bus.io_q         = q_q;
    // The only input-to-output path: the mode picks which end is "out".
    assign bus.io_serialOut = (bus.io_mode == USR_SHL) ? q_q[WIDTH-1] : q_q[0];
    assign bus.io_count     = count;
    assign bus.io_done      = (count == CNT_MAX);

endmodule
